// File: rtl/fetch_stage_pkg.sv
// Shared RV32I packet layout and fetch-stage types (states, reset PC, opcodes).
package rv32i_packet;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] next_pc;
      logic [31:0] instruction;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
   } rv32i_data_t;

   typedef struct packed {
      logic        valid;
      rv32i_data_t data;
   } rv32i_packet_t;

endpackage

package rv32i_types;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      DROP  = 2'd3
   } fetch_state_t;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0060;
   localparam logic [6:0]  OP_JAL           = 7'b1101111;
   localparam logic [6:0]  OP_BRANCH        = 7'b1100011;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'h3;
   endfunction

endpackage

// File: rtl/fetch_stage_predecode.sv
// Combinational predecode: extracts B/J immediates and predicts the next PC
// (backward-taken/forward-not-taken for branches, always-taken for JAL).
module fetch_predecode
   import rv32i_types::*;
#(
   parameter bit BTFN_EN = 1'b0
) (
   input  logic [31:0] pc,
   input  logic [31:0] instruction,
   output logic [31:0] next_pc
);

   logic [6:0]  opcode;
   logic [31:0] b_imm;
   logic [31:0] j_imm;
   logic [31:0] pc_plus4;

   always_comb begin
      opcode   = instruction[6:0];
      b_imm    = {{20{instruction[31]}}, instruction[7], instruction[30:25],
                  instruction[11:8], 1'b0};
      j_imm    = {{12{instruction[31]}}, instruction[19:12], instruction[20],
                  instruction[30:21], 1'b0};
      pc_plus4 = pc + 32'd4;
      next_pc  = pc_plus4;
      if (BTFN_EN) begin
         if (opcode == OP_JAL) begin
            next_pc = pc + j_imm;
         end else if (opcode == OP_BRANCH && b_imm[31]) begin
            next_pc = pc + b_imm;
         end
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, runs the I-mem handshake, feeds IF/ID.
// Define FETCH_BTFN_EN to predict next_pc from the fetched word (JAL / backward branch).
module fetch_stage
   import rv32i_types::*;
   import rv32i_packet::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          stall,
   input  logic          redirect,
   input  logic [31:0]   redirect_pc,
   input  logic          inst_mem_resp,
   input  logic [31:0]   inst_mem_rdata,
   output logic          inst_mem_read,
   output logic [31:0]   inst_mem_address,
   output rv32i_packet_t out_packet
);

`ifdef FETCH_BTFN_EN
   localparam bit BtfnEn = 1'b1;
`else
   localparam bit BtfnEn = 1'b0;
`endif

   fetch_state_t  state, state_next;
   logic [31:0]   pc, pc_next;
   logic [31:0]   pend_pc, pend_next;
   rv32i_packet_t hold, hold_next;
   rv32i_packet_t out_next;
   rv32i_packet_t fetched;
   logic [31:0]   predicted_pc;

   fetch_predecode #(.BTFN_EN(BtfnEn)) u_predecode (
      .pc          (pc),
      .instruction (inst_mem_rdata),
      .next_pc     (predicted_pc)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc         <= RESET_PC;
         pend_pc    <= '0;
         hold       <= '0;
         out_packet <= '0;
      end else begin
         pc         <= pc_next;
         pend_pc    <= pend_next;
         hold       <= hold_next;
         out_packet <= out_next;
      end
   end

   // Redirect outranks stall and resp; a stalled cycle freezes the packet unless redirected.
   always_comb begin
      fetched                  = '0;
      fetched.valid            = 1'b1;
      fetched.data.pc          = pc;
      fetched.data.instruction = inst_mem_rdata;
      fetched.data.next_pc     = word_align(predicted_pc);

      state_next = state;
      pc_next    = pc;
      pend_next  = pend_pc;
      hold_next  = hold;
      out_next   = out_packet;

      if (!stall) out_next.valid = 1'b0;
      if (redirect) begin
         out_next.valid = 1'b0;
         hold_next      = '0;
      end

      case (state)
         IDLE: begin
            state_next = FETCH;
            if (redirect) pc_next = word_align(redirect_pc);
         end
         FETCH: begin
            if (redirect) begin
               if (inst_mem_resp) begin
                  pc_next = word_align(redirect_pc);
               end else begin
                  pend_next  = word_align(redirect_pc);
                  state_next = DROP;
               end
            end else if (inst_mem_resp) begin
               if (stall) begin
                  hold_next  = fetched;
                  state_next = HOLD;
               end else begin
                  out_next = fetched;
                  pc_next  = fetched.data.next_pc;
               end
            end
         end
         HOLD: begin
            if (redirect) begin
               pc_next    = word_align(redirect_pc);
               state_next = FETCH;
            end else if (!stall) begin
               out_next   = hold;
               pc_next    = hold.data.next_pc;
               hold_next  = '0;
               state_next = FETCH;
            end
         end
         DROP: begin
            // A redirect landing with the stale resp jumps straight to the newest target,
            // since no further response will arrive for the abandoned request.
            if (redirect) begin
               pend_next = word_align(redirect_pc);
               if (inst_mem_resp) begin
                  pc_next    = word_align(redirect_pc);
                  state_next = FETCH;
               end
            end else if (inst_mem_resp) begin
               pc_next    = pend_pc;
               state_next = FETCH;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign inst_mem_read    = (state == FETCH) || (state == DROP);
   assign inst_mem_address = pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven self-checking bench for fetch_stage.
module tb_fetch_stage;
   import rv32i_packet::*;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] BEQN = 32'hFE00_0CE3;
   localparam logic [31:0] JAL  = 32'h0100_006F;
   localparam logic [31:0] BEQP = 32'h0000_0463;
   localparam logic [31:0] ADDI = 32'h0050_0093;
`ifdef FETCH_BTFN_EN
   localparam logic [31:0] BR_NEXT  = 32'h0000_0078;
   localparam logic [31:0] JAL_NEXT = 32'h0000_0010;
`else
   localparam logic [31:0] BR_NEXT  = 32'h0000_0084;
   localparam logic [31:0] JAL_NEXT = 32'h0000_0004;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          stall;
   logic          redirect;
   logic [31:0]   redirect_pc;
   logic          inst_mem_resp;
   logic [31:0]   inst_mem_rdata;
   logic          inst_mem_read;
   logic [31:0]   inst_mem_address;
   rv32i_packet_t out_packet;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          do_reset;
      bit          stall;
      bit          redirect;
      logic [31:0] rpc;
      bit          resp;
      logic [31:0] rdata;
      bit          e_read;
      logic [31:0] e_addr;
      bit          e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_np;
   } vec_t;

   vec_t vecs[$];

   fetch_stage dut (
      .clk              (clk),
      .rst              (rst),
      .stall            (stall),
      .redirect         (redirect),
      .redirect_pc      (redirect_pc),
      .inst_mem_resp    (inst_mem_resp),
      .inst_mem_rdata   (inst_mem_rdata),
      .inst_mem_read    (inst_mem_read),
      .inst_mem_address (inst_mem_address),
      .out_packet       (out_packet)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic add(input bit dr, input bit st, input bit rd, input logic [31:0] rpc,
                      input bit rs, input logic [31:0] rw, input bit er, input logic [31:0] ea,
                      input bit ev, input logic [31:0] ep, input logic [31:0] en);
      vec_t v;
      v = '{dr, st, rd, rpc, rs, rw, er, ea, ev, ep, en};
      vecs.push_back(v);
   endtask

   task automatic applyReset();
      stall = 0; redirect = 0; redirect_pc = '0; inst_mem_resp = 0; inst_mem_rdata = '0;
      rst = 1'b0;
      #2;
      checkOutput("rst_read", {31'b0, inst_mem_read}, 32'd0);
      checkOutput("rst_addr", inst_mem_address, 32'h60);
      checkOutput("rst_pkt_zero", {31'b0, out_packet == '0}, 32'd1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic applyStimulus(input vec_t v);
      if (v.do_reset) applyReset();
      stall          = v.stall;
      redirect       = v.redirect;
      redirect_pc    = v.rpc;
      inst_mem_resp  = v.resp;
      inst_mem_rdata = v.rdata;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; stall = 0; redirect = 0; redirect_pc = '0;
      inst_mem_resp = 0; inst_mem_rdata = '0;
      #1;

      // zero-wait stream of NOPs
      add(1,0,0,0,0,0,         1,32'h60,0,32'h0,32'h0);
      add(0,0,0,0,1,NOP,       1,32'h64,1,32'h60,32'h64);
      add(0,0,0,0,1,NOP,       1,32'h68,1,32'h64,32'h68);
      add(0,0,0,0,1,NOP,       1,32'h6C,1,32'h68,32'h6C);
      add(0,0,0,0,0,0,         1,32'h6C,0,32'h68,32'h6C);
      // resp for 0x64 under a 3-cycle stall
      add(1,0,0,0,0,0,         1,32'h60,0,32'h0,32'h0);
      add(0,0,0,0,1,NOP,       1,32'h64,1,32'h60,32'h64);
      add(0,1,0,0,1,NOP,       0,32'h64,1,32'h60,32'h64);
      add(0,1,0,0,0,0,         0,32'h64,1,32'h60,32'h64);
      add(0,1,0,0,0,0,         0,32'h64,1,32'h60,32'h64);
      add(0,0,0,0,0,0,         1,32'h68,1,32'h64,32'h68);
      add(0,0,0,0,0,0,         1,32'h68,0,32'h64,32'h68);
      // redirect (misaligned 0x202) two cycles into a 5-cycle wait
      add(1,0,0,0,0,0,         1,32'h60,0,32'h0,32'h0);
      add(0,0,0,0,1,NOP,       1,32'h64,1,32'h60,32'h64);
      add(0,0,0,0,0,0,         1,32'h64,0,32'h60,32'h64);
      add(0,0,1,32'h202,0,0,   1,32'h64,0,32'h60,32'h64);
      add(0,0,0,0,0,0,         1,32'h64,0,32'h60,32'h64);
      add(0,0,0,0,0,0,         1,32'h64,0,32'h60,32'h64);
      add(0,0,0,0,1,NOP,       1,32'h200,0,32'h60,32'h64);
      add(0,0,0,0,1,NOP,       1,32'h204,1,32'h200,32'h204);
      // redirect coincident with resp
      add(0,0,1,32'h300,1,NOP, 1,32'h300,0,32'h200,32'h204);
      add(0,0,0,0,1,NOP,       1,32'h304,1,32'h300,32'h304);
      // backward beq at 0x80
      add(0,0,1,32'h80,1,NOP,  1,32'h80,0,32'h300,32'h304);
      add(0,0,0,0,1,BEQN,      1,BR_NEXT,1,32'h80,BR_NEXT);
      add(0,0,0,0,0,0,         1,BR_NEXT,0,32'h80,BR_NEXT);
      // PC wrap
      add(0,0,1,32'hFFFF_FFFC,1,NOP, 1,32'hFFFF_FFFC,0,32'h80,BR_NEXT);
      add(0,0,0,0,1,NOP,       1,32'h0,1,32'hFFFF_FFFC,32'h0);
      // JAL and forward (not-taken) branch
      add(0,0,0,0,1,JAL,       1,JAL_NEXT,1,32'h0,JAL_NEXT);
      add(0,0,0,0,1,BEQP,      1,JAL_NEXT+4,1,JAL_NEXT,JAL_NEXT+4);
      // redirect under stall, then latest-redirect-wins in DROP
      add(0,1,1,32'h400,0,0,   1,JAL_NEXT+4,0,JAL_NEXT,JAL_NEXT+4);
      add(0,1,0,0,1,NOP,       1,32'h400,0,JAL_NEXT,JAL_NEXT+4);
      add(0,0,0,0,1,NOP,       1,32'h404,1,32'h400,32'h404);
      add(0,0,1,32'h500,0,0,   1,32'h404,0,32'h400,32'h404);
      add(0,0,1,32'h600,0,0,   1,32'h404,0,32'h400,32'h404);
      add(0,0,0,0,1,NOP,       1,32'h600,0,32'h400,32'h404);
      add(0,0,0,0,1,NOP,       1,32'h604,1,32'h600,32'h604);
      // redirect while holding
      add(0,1,0,0,1,NOP,       0,32'h604,1,32'h600,32'h604);
      add(0,1,1,32'h700,0,0,   1,32'h700,0,32'h600,32'h604);
      add(0,0,0,0,1,NOP,       1,32'h704,1,32'h700,32'h704);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("v%0d_read", i), {31'b0, inst_mem_read}, {31'b0, vecs[i].e_read});
         checkOutput($sformatf("v%0d_addr", i), inst_mem_address, vecs[i].e_addr);
         checkOutput($sformatf("v%0d_valid", i), {31'b0, out_packet.valid}, {31'b0, vecs[i].e_valid});
         checkOutput($sformatf("v%0d_pc", i), out_packet.data.pc, vecs[i].e_pc);
         checkOutput($sformatf("v%0d_next_pc", i), out_packet.data.next_pc, vecs[i].e_np);
      end

      // reset asserted mid-request, then a late resp while in IDLE
      inst_mem_resp = 0; stall = 0; redirect = 0;
      #2;
      rst = 1'b0;
      #1;
      checkOutput("midrst_read", {31'b0, inst_mem_read}, 32'd0);
      checkOutput("midrst_addr", inst_mem_address, 32'h60);
      checkOutput("midrst_valid", {31'b0, out_packet.valid}, 32'd0);
      inst_mem_resp = 1; inst_mem_rdata = ADDI;
      @(posedge clk);
      #1;
      checkOutput("inrst_read", {31'b0, inst_mem_read}, 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("late_valid", {31'b0, out_packet.valid}, 32'd0);
      checkOutput("late_addr", inst_mem_address, 32'h60);
      checkOutput("late_read", {31'b0, inst_mem_read}, 32'd1);
      @(posedge clk);
      #1;
      checkOutput("first_valid", {31'b0, out_packet.valid}, 32'd1);
      checkOutput("first_pc", out_packet.data.pc, 32'h60);
      checkOutput("first_inst", out_packet.data.instruction, ADDI);
      checkOutput("first_np", out_packet.data.next_pc, 32'h64);
      checkOutput("first_imm", out_packet.data.imm, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
